// File: rtl/frame_buffer_arbiter_if.sv
// Memory command port of the frame buffer arbiter.
// master: driven by the arbiter (command valid/write/address), receives ready and done.
// slave : the memory side (accepts commands, reports burst completion).
interface frame_buffer_arbiter_if;
  logic        mem_cmd_valid;
  logic        mem_cmd_ready;
  logic        mem_cmd_write;
  logic [31:0] mem_addr;
  logic        mem_done;

  modport master (
    output mem_cmd_valid,
    output mem_cmd_write,
    output mem_addr,
    input  mem_cmd_ready,
    input  mem_done
  );

  modport slave (
    input  mem_cmd_valid,
    input  mem_cmd_write,
    input  mem_addr,
    output mem_cmd_ready,
    output mem_done
  );
endinterface

// File: rtl/frame_buffer_arbiter.sv
// Triple-buffered frame store arbiter between an HDMI RX writer and an HDMI TX reader
// sharing one DDR3 command port.
// Ports:
//   clk, reset                  single clock, asynchronous active-high reset
//   wr_req, rd_req, rd_urgent   client burst requests (levels); rd_urgent forces read priority
//   rx_frame_start              RX VSYNC pulse: rotate the write buffer
//   tx_frame_start              TX VSYNC pulse: pick up the latest completed frame
//   wr_grant, rd_grant          owner of the current burst (held ISSUE through mem_done)
//   mem                         command port (valid/ready/write/addr, done pulse)
//   wr_buf, rd_buf              buffer indices being written / displayed
//   repeat_count                saturating count of TX frames that re-showed a buffer
module frame_buffer_arbiter #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter logic [31:0] FRAME_BYTES = 32'h0080_0000,
  parameter int unsigned BURST_BYTES = 256
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_req,
  input  logic                        rd_req,
  input  logic                        rd_urgent,
  input  logic                        rx_frame_start,
  input  logic                        tx_frame_start,
  output logic                        wr_grant,
  output logic                        rd_grant,
  frame_buffer_arbiter_if.master      mem,
  output logic [1:0]                  wr_buf,
  output logic [1:0]                  rd_buf,
  output logic [7:0]                  repeat_count
);

  localparam logic [31:0] BurstInc = 32'(BURST_BYTES);

  typedef enum logic [1:0] {StIdle, StIssue, StBusy} state_e;

  state_e      state_q, state_d;
  logic        cmd_write_q, cmd_write_d;
  logic [31:0] addr_q, addr_d;
  logic        last_wr_q, last_wr_d;
  logic [1:0]  wr_buf_q, wr_buf_d;
  logic [1:0]  rd_buf_q, rd_buf_d;
  logic [1:0]  latest_q, latest_d;
  logic        fresh_q, fresh_d;
  logic [31:0] wr_off_q, wr_off_d;
  logic [31:0] rd_off_q, rd_off_d;
  logic [7:0]  rep_q, rep_d;
  // Set when a frame start reset the offset of the burst currently in flight, so that
  // burst's completion must not advance the freshly cleared offset.
  logic        wr_skip_q, wr_skip_d;
  logic        rd_skip_q, rd_skip_d;

  logic        start;
  logic        sel_wr;
  logic        burst_done;
  logic        inflight_wr;
  logic        inflight_rd;
  logic [31:0] sel_buf_ext;
  logic [31:0] sel_off;
  logic [31:0] wr_off_inc;
  logic [31:0] rd_off_inc;

  // Next-state logic for the command FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (wr_req || rd_req) state_d = StIssue;
      StIssue: if (mem.mem_cmd_ready) state_d = StBusy;
      StBusy:  if (mem.mem_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Arbitration, address latch, offsets and buffer rotation.
  always_comb begin
    sel_wr = 1'b0;
    if (rd_req && rd_urgent) begin
      sel_wr = 1'b0;
    end else if (wr_req && !rd_req) begin
      sel_wr = 1'b1;
    end else if (rd_req && !wr_req) begin
      sel_wr = 1'b0;
    end else begin
      sel_wr = !last_wr_q;
    end

    start       = (state_q == StIdle) && (wr_req || rd_req);
    burst_done  = (state_q == StBusy) && mem.mem_done;
    inflight_wr = ((state_q != StIdle) && cmd_write_q) || (start && sel_wr);
    inflight_rd = ((state_q != StIdle) && !cmd_write_q) || (start && !sel_wr);

    sel_buf_ext = {30'd0, (sel_wr ? wr_buf_q : rd_buf_q)};
    sel_off     = sel_wr ? wr_off_q : rd_off_q;
    wr_off_inc  = (wr_off_q + BurstInc == FRAME_BYTES) ? 32'd0 : wr_off_q + BurstInc;
    rd_off_inc  = (rd_off_q + BurstInc == FRAME_BYTES) ? 32'd0 : rd_off_q + BurstInc;

    cmd_write_d = cmd_write_q;
    addr_d      = addr_q;
    last_wr_d   = last_wr_q;
    wr_buf_d    = wr_buf_q;
    rd_buf_d    = rd_buf_q;
    latest_d    = latest_q;
    fresh_d     = fresh_q;
    wr_off_d    = wr_off_q;
    rd_off_d    = rd_off_q;
    rep_d       = rep_q;
    wr_skip_d   = wr_skip_q;
    rd_skip_d   = rd_skip_q;

    // Address uses the pointers as they stood before any same-cycle frame start.
    if (start) begin
      cmd_write_d = sel_wr;
      addr_d      = BASE_ADDR + sel_buf_ext * FRAME_BYTES + sel_off;
      last_wr_d   = sel_wr;
      wr_skip_d   = 1'b0;
      rd_skip_d   = 1'b0;
    end

    if (burst_done && cmd_write_q && !wr_skip_q) wr_off_d = wr_off_inc;
    if (burst_done && !cmd_write_q && !rd_skip_q) rd_off_d = rd_off_inc;

    // Frame starts come last so their offset clear wins over a same-cycle increment.
    if (rx_frame_start) begin
      latest_d = wr_buf_q;
      wr_buf_d = 2'd3 - wr_buf_q - rd_buf_q;  // the one index in {0,1,2} not in use
      wr_off_d = 32'd0;
      fresh_d  = 1'b1;
      if (inflight_wr) wr_skip_d = 1'b1;
    end

    if (tx_frame_start) begin
      rd_off_d = 32'd0;
      if (inflight_rd) rd_skip_d = 1'b1;
      if (rx_frame_start || fresh_q) begin
        // A same-cycle RX rotation makes the old write buffer the newest frame.
        rd_buf_d = rx_frame_start ? wr_buf_q : latest_q;
        fresh_d  = 1'b0;
      end else if (rep_q != 8'hff) begin
        rep_d = rep_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cmd_write_q <= 1'b0;
      addr_q      <= 32'd0;
      last_wr_q   <= 1'b1;
      wr_buf_q    <= 2'd0;
      rd_buf_q    <= 2'd1;
      latest_q    <= 2'd1;
      fresh_q     <= 1'b0;
      wr_off_q    <= 32'd0;
      rd_off_q    <= 32'd0;
      rep_q       <= 8'd0;
      wr_skip_q   <= 1'b0;
      rd_skip_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_write_q <= cmd_write_d;
      addr_q      <= addr_d;
      last_wr_q   <= last_wr_d;
      wr_buf_q    <= wr_buf_d;
      rd_buf_q    <= rd_buf_d;
      latest_q    <= latest_d;
      fresh_q     <= fresh_d;
      wr_off_q    <= wr_off_d;
      rd_off_q    <= rd_off_d;
      rep_q       <= rep_d;
      wr_skip_q   <= wr_skip_d;
      rd_skip_q   <= rd_skip_d;
    end
  end

  assign mem.mem_cmd_valid = (state_q == StIssue);
  assign mem.mem_cmd_write = cmd_write_q;
  assign mem.mem_addr      = addr_q;
  assign wr_grant          = (state_q != StIdle) && cmd_write_q;
  assign rd_grant          = (state_q != StIdle) && !cmd_write_q;
  assign wr_buf            = wr_buf_q;
  assign rd_buf            = rd_buf_q;
  assign repeat_count      = rep_q;

endmodule
